// File: rtl/tinygpu_pkg.sv
// Shared types and sizes for the SP core issue path.
// Holds data/register widths, the opcode set and the issue/execute bundles.
package tinygpu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 4;
    localparam int NREG   = 2 ** REG_W;
    localparam int OP_W   = 6;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 6'h00,
        OP_ADD = 6'h01,
        OP_SUB = 6'h02,
        OP_AND = 6'h03,
        OP_OR  = 6'h04,
        OP_XOR = 6'h05,
        OP_SHL = 6'h06,
        OP_SHR = 6'h07,
        OP_MUL = 6'h08,
        OP_LD  = 6'h10,
        OP_ST  = 6'h11,
        OP_BR  = 6'h20
    } opcode_e;

    // Decoded instruction as presented to the issue stage.
    // src_use bit order is {C,B,A}.
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [2:0]       src_use;
        logic [REG_W-1:0] nA;
        logic [REG_W-1:0] nB;
        logic [REG_W-1:0] nC;
        logic [REG_W-1:0] nD;
        logic             wr;
    } issue_t;

    // Registered bundle handed to execute.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] A;
        logic [DATA_W-1:0] B;
        logic [DATA_W-1:0] C;
        logic [REG_W-1:0]  nD;
        logic              wr;
    } ex_bundle_t;

    function automatic logic [NREG-1:0] reg_mask(input logic [REG_W-1:0] idx);
        return NREG'(1) << idx;
    endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// In-flight destination tracker: one pending bit per architectural register.
// Ports: clk/Reset; set (issue of a writing instruction), clr (writeback);
// four lookups (three sources + destination) returning pending bits;
// sb_err is sticky and flags a writeback to a register that was not pending.
module operand_fetch_scoreboard
    import tinygpu_pkg::*;
(
    input  logic             clk,
    input  logic             Reset,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_idx,
    input  logic [REG_W-1:0] look_a,
    input  logic [REG_W-1:0] look_b,
    input  logic [REG_W-1:0] look_c,
    input  logic [REG_W-1:0] look_d,
    output logic             hit_a,
    output logic             hit_b,
    output logic             hit_c,
    output logic             hit_d,
    output logic             sb_err
);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;

    // Clear first, then set: a new write issued in the same cycle as a
    // writeback to that register is still in flight, so the set wins.
    always_comb begin
        pending_nxt = pending;
        if (clr_en) begin
            pending_nxt = pending_nxt & ~reg_mask(clr_idx);
        end
        if (set_en) begin
            pending_nxt = pending_nxt | reg_mask(set_idx);
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            pending <= '0;
            sb_err  <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (clr_en && !pending[clr_idx]) begin
                sb_err <= 1'b1;
            end
        end
    end

    assign hit_a = pending[look_a];
    assign hit_b = pending[look_b];
    assign hit_c = pending[look_c];
    assign hit_d = pending[look_d];

endmodule

// File: rtl/operand_fetch.sv
// Issue/operand-fetch stage: reads operands, tracks in-flight writes, stalls
// on RAW/WAW hazards and registers the bundle to execute.
// Ports: in_* decoded instruction (valid/ready), rf_* register file read
// addresses/data and write port, ex_* registered bundle (valid/ready),
// wb_* writeback bus, sb_err sticky scoreboard error.
// Option TINYGPU_WB_BYPASS_EN: forward wb_data to same-cycle dependents.
module operand_fetch
    import tinygpu_pkg::*;
(
    input  logic              clk,
    input  logic              Reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [2:0]        in_use,
    input  logic [REG_W-1:0]  in_nA,
    input  logic [REG_W-1:0]  in_nB,
    input  logic [REG_W-1:0]  in_nC,
    input  logic [REG_W-1:0]  in_nD,
    input  logic              in_wr,
    output logic [REG_W-1:0]  rf_nA,
    output logic [REG_W-1:0]  rf_nB,
    output logic [REG_W-1:0]  rf_nC,
    input  logic [DATA_W-1:0] rf_A,
    input  logic [DATA_W-1:0] rf_B,
    input  logic [DATA_W-1:0] rf_C,
    output logic [REG_W-1:0]  rf_nD,
    output logic [DATA_W-1:0] rf_D,
    output logic              rf_RegWE,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [OP_W-1:0]   ex_op,
    output logic [DATA_W-1:0] ex_A,
    output logic [DATA_W-1:0] ex_B,
    output logic [DATA_W-1:0] ex_C,
    output logic [REG_W-1:0]  ex_nD,
    output logic              ex_wr,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_nD,
    input  logic [DATA_W-1:0] wb_data,
    output logic              sb_err
);

    issue_t     iss;
    ex_bundle_t ex_q;

    logic hit_a, hit_b, hit_c, hit_d;
    logic fwd_a, fwd_b, fwd_c, fwd_d;
    logic haz_a, haz_b, haz_c, haz_d;
    logic hazard;
    logic accept;

    logic [DATA_W-1:0] opnd_a, opnd_b, opnd_c;

    assign iss = '{
        op:      in_op,
        src_use: in_use,
        nA:      in_nA,
        nB:      in_nB,
        nC:      in_nC,
        nD:      in_nD,
        wr:      in_wr
    };

    assign rf_nA    = iss.nA;
    assign rf_nB    = iss.nB;
    assign rf_nC    = iss.nC;
    assign rf_nD    = wb_nD;
    assign rf_D     = wb_data;
    assign rf_RegWE = wb_valid;

    operand_fetch_scoreboard u_sb (
        .clk     (clk),
        .Reset   (Reset),
        .set_en  (accept && iss.wr),
        .set_idx (iss.nD),
        .clr_en  (wb_valid),
        .clr_idx (wb_nD),
        .look_a  (iss.nA),
        .look_b  (iss.nB),
        .look_c  (iss.nC),
        .look_d  (iss.nD),
        .hit_a   (hit_a),
        .hit_b   (hit_b),
        .hit_c   (hit_c),
        .hit_d   (hit_d),
        .sb_err  (sb_err)
    );

`ifdef TINYGPU_WB_BYPASS_EN
    // A register being written back this cycle is resolved already:
    // take its value straight off the writeback bus.
    assign fwd_a = wb_valid && (wb_nD == iss.nA);
    assign fwd_b = wb_valid && (wb_nD == iss.nB);
    assign fwd_c = wb_valid && (wb_nD == iss.nC);
    assign fwd_d = wb_valid && (wb_nD == iss.nD);
`else
    // Pending bits clear only at the edge; dependents wait one cycle
    // and then read the freshly written register file.
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
    assign fwd_c = 1'b0;
    assign fwd_d = 1'b0;
`endif

    assign haz_a  = iss.src_use[0] && hit_a && !fwd_a;
    assign haz_b  = iss.src_use[1] && hit_b && !fwd_b;
    assign haz_c  = iss.src_use[2] && hit_c && !fwd_c;
    assign haz_d  = iss.wr && hit_d && !fwd_d;
    assign hazard = haz_a || haz_b || haz_c || haz_d;

    assign opnd_a = fwd_a ? wb_data : rf_A;
    assign opnd_b = fwd_b ? wb_data : rf_B;
    assign opnd_c = fwd_c ? wb_data : rf_C;

    assign in_ready = !hazard && (!ex_valid || ex_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            ex_valid <= 1'b0;
            ex_q     <= '0;
        end else if (accept) begin
            ex_valid <= 1'b1;
            ex_q     <= '{
                op: iss.op,
                A:  opnd_a,
                B:  opnd_b,
                C:  opnd_c,
                nD: iss.nD,
                wr: iss.wr
            };
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    assign ex_op = ex_q.op;
    assign ex_A  = ex_q.A;
    assign ex_B  = ex_q.B;
    assign ex_C  = ex_q.C;
    assign ex_nD = ex_q.nD;
    assign ex_wr = ex_q.wr;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed scenarios then random traffic
// against a register-level reference model; honours TINYGPU_WB_BYPASS_EN.
module tb_operand_fetch;
    import tinygpu_pkg::*;

`ifdef TINYGPU_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              Reset;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [2:0]        in_use;
    logic [REG_W-1:0]  in_nA, in_nB, in_nC, in_nD;
    logic              in_wr;
    logic [REG_W-1:0]  rf_nA, rf_nB, rf_nC, rf_nD;
    logic [DATA_W-1:0] rf_A, rf_B, rf_C, rf_D;
    logic              rf_RegWE;
    logic              ex_valid, ex_ready;
    logic [OP_W-1:0]   ex_op;
    logic [DATA_W-1:0] ex_A, ex_B, ex_C;
    logic [REG_W-1:0]  ex_nD;
    logic              ex_wr;
    logic              wb_valid;
    logic [REG_W-1:0]  wb_nD;
    logic [DATA_W-1:0] wb_data;
    logic              sb_err;

    operand_fetch dut (
        .clk(clk), .Reset(Reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_use(in_use), .in_nA(in_nA), .in_nB(in_nB), .in_nC(in_nC),
        .in_nD(in_nD), .in_wr(in_wr),
        .rf_nA(rf_nA), .rf_nB(rf_nB), .rf_nC(rf_nC),
        .rf_A(rf_A), .rf_B(rf_B), .rf_C(rf_C),
        .rf_nD(rf_nD), .rf_D(rf_D), .rf_RegWE(rf_RegWE),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
        .ex_A(ex_A), .ex_B(ex_B), .ex_C(ex_C), .ex_nD(ex_nD), .ex_wr(ex_wr),
        .wb_valid(wb_valid), .wb_nD(wb_nD), .wb_data(wb_data),
        .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a, b, c;
        logic [REG_W-1:0]  nd;
        logic              wr;
        logic [2:0]        u;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    // Reference state: architectural registers, outstanding writes,
    // whether execute holds an instruction, sticky error.
    logic [DATA_W-1:0] regs [NREG];
    bit                pend [NREG];
    bit                m_exv, m_err;
    bit                wpend;
    logic [REG_W-1:0]  wn;
    logic [DATA_W-1:0] wd;
    exp_t              mon_e;

    // The bench is the register file.
    assign rf_A = regs[rf_nA];
    assign rf_B = regs[rf_nB];
    assign rf_C = regs[rf_nC];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    function automatic bit on_wb(input logic [REG_W-1:0] r);
        return BYP && wb_valid && (wb_nD == r);
    endfunction

    function automatic bit blocked(input logic [REG_W-1:0] r);
        return pend[r] && !on_wb(r);
    endfunction

    function automatic logic [DATA_W-1:0] value(input logic [REG_W-1:0] r);
        return on_wb(r) ? wb_data : regs[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) pend[i] = 1'b0;
        m_exv = 1'b0;
        m_err = 1'b0;
        wpend = 1'b0;
        q.delete();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_use   = 3'b000;
        in_wr    = 1'b0;
        wb_valid = 1'b0;
    endtask

    task automatic set_in(input logic [OP_W-1:0] op, input logic [2:0] u,
                          input logic [REG_W-1:0] a, input logic [REG_W-1:0] b,
                          input logic [REG_W-1:0] c, input logic [REG_W-1:0] d,
                          input logic wr);
        in_valid = 1'b1;
        in_op    = op;
        in_use   = u;
        in_nA    = a;
        in_nB    = b;
        in_nC    = c;
        in_nD    = d;
        in_wr    = wr;
    endtask

    // Called just after a rising edge with inputs already driven; checks
    // the stage against the model, predicts the coming edge, then steps.
    task automatic cycle();
        bit   haz, rdy;
        exp_t e;
        #1;
        chk("ex_valid", 32'(ex_valid), 32'(m_exv));
        chk("sb_err", 32'(sb_err), 32'(m_err));
        chk("rf_we", 32'(rf_RegWE), 32'(wb_valid));
        if (wb_valid) begin
            chk("rf_nD", 32'(rf_nD), 32'(wb_nD));
            chk("rf_D", 32'(rf_D), 32'(wb_data));
        end
        haz = (in_use[0] && blocked(in_nA)) || (in_use[1] && blocked(in_nB)) ||
              (in_use[2] && blocked(in_nC)) || (in_wr && blocked(in_nD));
        rdy = !haz && (!m_exv || ex_ready);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        if (in_valid && rdy) begin
            e.op = in_op;
            e.a  = value(in_nA);
            e.b  = value(in_nB);
            e.c  = value(in_nC);
            e.nd = in_nD;
            e.wr = in_wr;
            e.u  = in_use;
            q.push_back(e);
        end
        if (wb_valid) begin
            if (!pend[wb_nD]) m_err = 1'b1;
            pend[wb_nD] = 1'b0;
            wpend = 1'b1;
            wn = wb_nD;
            wd = wb_data;
        end
        if (in_valid && rdy) begin
            m_exv = 1'b1;
            if (in_wr) pend[in_nD] = 1'b1;
        end else if (ex_ready) begin
            m_exv = 1'b0;
        end
        @(posedge clk);
        #1;
        if (wpend) regs[wn] = wd;
        wpend = 1'b0;
    endtask

    // Monitor: whatever execute sees must be the oldest expected issue.
    always @(negedge clk) begin
        if (!Reset && ex_valid) begin
            if (q.size() == 0) begin
                chk("ex_unexpected", 32'(ex_valid), 32'(0));
            end else begin
                mon_e = q[0];
                chk("ex_op", 32'(ex_op), 32'(mon_e.op));
                chk("ex_nD", 32'(ex_nD), 32'(mon_e.nd));
                chk("ex_wr", 32'(ex_wr), 32'(mon_e.wr));
                if (mon_e.u[0]) chk("ex_A", 32'(ex_A), 32'(mon_e.a));
                if (mon_e.u[1]) chk("ex_B", 32'(ex_B), 32'(mon_e.b));
                if (mon_e.u[2]) chk("ex_C", 32'(ex_C), 32'(mon_e.c));
                if (ex_ready) void'(q.pop_front());
            end
        end
    end

    function automatic logic [REG_W-1:0] rnd_reg();
        if ($urandom_range(0, 7) == 0) return REG_W'($urandom_range(0, NREG - 1));
        return REG_W'($urandom_range(0, 3));
    endfunction

    task automatic rand_phase(input int n, input bit spur);
        int               start;
        logic [REG_W-1:0] idx;
        bit               found;
        for (int t = 0; t < n; t++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_op    = OP_W'($urandom);
            in_use   = 3'($urandom);
            in_nA    = rnd_reg();
            in_nB    = rnd_reg();
            in_nC    = rnd_reg();
            in_nD    = rnd_reg();
            in_wr    = 1'($urandom_range(0, 1));
            ex_ready = ($urandom_range(0, 3) != 0);
            wb_valid = 1'b0;
            wb_data  = DATA_W'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                start = int'($urandom_range(0, NREG - 1));
                found = 1'b0;
                for (int k = 0; k < NREG; k++) begin
                    idx = REG_W'(start + k);
                    if (!found && pend[idx]) begin
                        found    = 1'b1;
                        wb_valid = 1'b1;
                        wb_nD    = idx;
                    end
                end
            end
            if (!wb_valid && spur && $urandom_range(0, 40) == 0) begin
                wb_valid = 1'b1;
                wb_nD    = REG_W'($urandom_range(0, NREG - 1));
            end
            cycle();
        end
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) regs[i] = {8'h00, 4'(i), 4'(i)};
        model_reset();
        Reset    = 1'b1;
        idle();
        in_op    = '0;
        in_nA    = '0;
        in_nB    = '0;
        in_nC    = '0;
        in_nD    = '0;
        ex_ready = 1'b1;
        wb_nD    = '0;
        wb_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", 32'(ex_valid), 32'(0));
        chk("rst_ex_op", 32'(ex_op), 32'(0));
        chk("rst_ex_A", 32'(ex_A), 32'(0));
        chk("rst_sb_err", 32'(sb_err), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        Reset = 1'b0;

        // First issue: ADD r3 <- r1, r2.
        set_in(6'h01, 3'b011, 4'd1, 4'd2, 4'd0, 4'd3, 1'b1);
        cycle();
        chk("first_valid", 32'(ex_valid), 32'(1));
        chk("first_A", 32'(ex_A), 32'h0011);
        chk("first_B", 32'(ex_B), 32'h0022);
        chk("first_nD", 32'(ex_nD), 32'(3));

        // Dependent on r3: stalls until the writeback.
        set_in(6'h02, 3'b001, 4'd3, 4'd0, 4'd0, 4'd0, 1'b0);
        #1;
        chk("raw_stall", 32'(in_ready), 32'(0));
        cycle();
        wb_valid = 1'b1;
        wb_nD    = 4'd3;
        wb_data  = 16'hBEEF;
        #1;
        chk("raw_wb_ready", 32'(in_ready), 32'(BYP));
        cycle();
        wb_valid = 1'b0;
        if (ex_op != 6'h02) cycle();
        chk("raw_op", 32'(ex_op), 32'h02);
        chk("raw_A", 32'(ex_A), 32'hBEEF);
        idle();
        cycle();

        // Backpressure: execute holds for three cycles, then refill.
        set_in(6'h06, 3'b111, 4'd1, 4'd2, 4'd4, 4'd8, 1'b0);
        cycle();
        ex_ready = 1'b0;
        set_in(6'h07, 3'b000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_hold_op", 32'(ex_op), 32'h06);
        end
        ex_ready = 1'b1;
        cycle();
        chk("bp_refill_op", 32'(ex_op), 32'h07);
        idle();
        cycle();
        cycle();

        // Same-cycle set and clear on r5.
        set_in(6'h04, 3'b000, 4'd0, 4'd0, 4'd0, 4'd5, 1'b1);
        cycle();
        set_in(6'h05, 3'b000, 4'd0, 4'd0, 4'd0, 4'd5, 1'b1);
        wb_valid = 1'b1;
        wb_nD    = 4'd5;
        wb_data  = 16'h5555;
        cycle();
        wb_valid = 1'b0;
        if (ex_op != 6'h05) cycle();
        idle();
        cycle();
        set_in(6'h03, 3'b001, 4'd5, 4'd0, 4'd0, 4'd0, 1'b0);
        #1;
        chk("setclr_pending", 32'(in_ready), 32'(0));
        cycle();
        wb_valid = 1'b1;
        wb_nD    = 4'd5;
        wb_data  = 16'h0A05;
        cycle();
        wb_valid = 1'b0;
        cycle();
        idle();
        cycle();
        chk("setclr_err", 32'(sb_err), 32'(0));

        // Spurious writeback to r7.
        wb_valid = 1'b1;
        wb_nD    = 4'd7;
        wb_data  = 16'h7777;
        #1;
        chk("spur_we", 32'(rf_RegWE), 32'(1));
        chk("spur_nD", 32'(rf_nD), 32'(7));
        cycle();
        idle();
        cycle();
        chk("spur_err", 32'(sb_err), 32'(1));

        rand_phase(300, 1'b0);

        // Reset while execute is stalled and r3 is pending.
        idle();
        ex_ready = 1'b1;
        repeat (4) cycle();
        wb_valid = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (pend[i]) begin
                wb_valid = 1'b1;
                wb_nD    = REG_W'(i);
                cycle();
            end
        end
        idle();
        cycle();
        set_in(6'h09, 3'b001, 4'd1, 4'd0, 4'd0, 4'd3, 1'b1);
        cycle();
        idle();
        ex_ready = 1'b0;
        cycle();
        #1;
        Reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(ex_valid), 32'(0));
        chk("mid_rst_A", 32'(ex_A), 32'(0));
        chk("mid_rst_nD", 32'(ex_nD), 32'(0));
        chk("mid_rst_wr", 32'(ex_wr), 32'(0));
        chk("mid_rst_err", 32'(sb_err), 32'(0));
        chk("mid_rst_ready", 32'(in_ready), 32'(1));
        model_reset();
        @(posedge clk);
        #1;
        Reset    = 1'b0;
        ex_ready = 1'b1;
        set_in(6'h0A, 3'b001, 4'd3, 4'd0, 4'd0, 4'd0, 1'b0);
        cycle();

        rand_phase(400, 1'b1);

        idle();
        ex_ready = 1'b1;
        repeat (3) cycle();
        chk("drain", 32'(q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
